control_partida: RTL and testbench

Game-sequencing controller for the Connect-Four datapath. It starts the match by pulsing `listo` to the turn register, accepts or rejects column moves from the current player, and tracks per-column fill heights. It issues one board write per accepted move, hands off to the win checker, then pulses `ficha_colocada` so the turn flips. It also enforces a per-turn countdown: on timeout it auto-plays the lowest-index non-full column.

---
 rtl/control_partida.sv | 208 ++++++++++++++++++++
 tb/tb_control_partida.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_partida.sv
// control_partida: game-sequencing controller for the Connect-Four datapath.
// Starts a match, validates column moves, tracks per-column fill heights,
// issues one board write per accepted move, hands off to the win checker and
// enforces a per-turn countdown. On timeout the lowest-index free column is
// played automatically.
//
// Parameters
//   COLS     board columns (max 8)
//   ROWS     board rows (max 7)
//   CLK_HZ   clock cycles per one-second tick
//   TURN_SEC seconds allowed per turn (1..15)
// Ports
//   clk             clock, all state on rising edge
//   reset           asynchronous active-low reset
//   inicio          start-game pulse
//   col_sel         column chosen by the current player
//   confirmar       single-cycle pulse confirming col_sel
//   is_red          current turn from the turn register (1 = red)
//   chequeo_listo   win checker done
//   hay_ganador     win result, valid with chequeo_listo
//   listo           one-cycle pulse, first player selected
//   wr_en           board write strobe
//   wr_fila/wr_col  row (0 = bottom) / column written
//   wr_color        colour written (1 = red)
//   chequeo_req     win-check request, held until chequeo_listo
//   ficha_colocada  one-cycle pulse after a completed non-final move
//   jugada_invalida one-cycle pulse on a rejected confirmar
//   segundos        seconds remaining in the current turn
//   estado_juego    0 idle, 1 playing, 2 win, 3 draw
//   ganador         winning colour, valid when estado_juego = 2
module control_partida #(
  parameter int unsigned COLS     = 7,
  parameter int unsigned ROWS     = 6,
  parameter int unsigned CLK_HZ   = 50_000_000,
  parameter int unsigned TURN_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [2:0] col_sel,
  input  logic       confirmar,
  input  logic       is_red,
  input  logic       chequeo_listo,
  input  logic       hay_ganador,
  output logic       listo,
  output logic       wr_en,
  output logic [2:0] wr_fila,
  output logic [2:0] wr_col,
  output logic       wr_color,
  output logic       chequeo_req,
  output logic       ficha_colocada,
  output logic       jugada_invalida,
  output logic [3:0] segundos,
  output logic [1:0] estado_juego,
  output logic       ganador
);

  typedef enum logic [2:0] {
    IDLE,
    ESPERA,
    ESCRIBE,
    VERIFICA,
    CAMBIO,
    FIN_GANA,
    FIN_EMPATE
  } state_t;

  localparam int unsigned   TW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [5:0]    TOTAL     = 6'(ROWS * COLS);
  localparam logic [3:0]    SEC_INIT  = 4'(TURN_SEC);
  localparam logic [2:0]    ROWS_L    = 3'(ROWS);
  localparam logic [3:0]    COLS_L    = 4'(COLS);

  state_t        state;
  state_t        next;
  logic [2:0]    altura [COLS];
  logic [5:0]    movs;
  logic [2:0]    col_q;
  logic [TW-1:0] tick_cnt;

  logic [2:0]    altura_sel;
  logic [2:0]    altura_wr;
  logic          sel_ok;
  logic [2:0]    auto_col;
  logic          auto_found;
  logic          tick;
  logic          timeout;

  // Height lookups go through loops so a col_sel beyond COLS never indexes
  // past the array; it simply reads as zero and is rejected by the range test.
  always_comb begin
    altura_sel = '0;
    altura_wr  = '0;
    auto_col   = '0;
    auto_found = 1'b0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (col_sel == 3'(i)) altura_sel = altura[i];
      if (col_q == 3'(i))   altura_wr  = altura[i];
      if (!auto_found && (altura[i] < ROWS_L)) begin
        auto_col   = 3'(i);
        auto_found = 1'b1;
      end
    end
  end

  assign sel_ok  = ({1'b0, col_sel} < COLS_L) && (altura_sel < ROWS_L);
  assign tick    = (state == ESPERA) && (tick_cnt == TICK_LAST);
  assign timeout = tick && (segundos == 4'd1);

  always_comb begin
    next           = state;
    wr_en          = 1'b0;
    wr_fila        = '0;
    wr_col         = '0;
    wr_color       = 1'b0;
    chequeo_req    = 1'b0;
    ficha_colocada = 1'b0;
    estado_juego   = 2'd1;
    case (state)
      IDLE: begin
        estado_juego = 2'd0;
        if (inicio) next = ESPERA;
      end
      ESPERA: begin
        // A valid confirm and a timeout both lead to ESCRIBE; which column
        // gets latched is resolved in the register block.
        if ((confirmar && sel_ok) || timeout) next = ESCRIBE;
      end
      ESCRIBE: begin
        wr_en    = 1'b1;
        wr_fila  = altura_wr;
        wr_col   = col_q;
        wr_color = is_red;
        next     = VERIFICA;
      end
      VERIFICA: begin
        chequeo_req = 1'b1;
        if (chequeo_listo) begin
          if (hay_ganador)        next = FIN_GANA;
          else if (movs == TOTAL) next = FIN_EMPATE;
          else                    next = CAMBIO;
        end
      end
      CAMBIO: begin
        ficha_colocada = 1'b1;
        next           = ESPERA;
      end
      FIN_GANA: begin
        estado_juego = 2'd2;
      end
      FIN_EMPATE: begin
        estado_juego = 2'd3;
      end
      default: begin
        estado_juego = 2'd0;
        next         = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      altura          <= '{default: '0};
      movs            <= '0;
      col_q           <= '0;
      tick_cnt        <= '0;
      segundos        <= SEC_INIT;
      listo           <= 1'b0;
      jugada_invalida <= 1'b0;
      ganador         <= 1'b0;
    end else begin
      state           <= next;
      listo           <= (state == IDLE) && inicio;
      jugada_invalida <= (state == ESPERA) && confirmar && !sel_ok;
      case (state)
        IDLE: begin
          altura   <= '{default: '0};
          movs     <= '0;
          tick_cnt <= '0;
          segundos <= SEC_INIT;
        end
        ESPERA: begin
          // Counter restarts at every wrap and whenever ESPERA is left, so
          // each turn starts with a full second on the clock.
          if (tick || (next != ESPERA)) tick_cnt <= '0;
          else                          tick_cnt <= tick_cnt + 1'b1;
          if (tick && (segundos != 4'd0)) segundos <= segundos - 4'd1;
          if (next == ESCRIBE) col_q <= (confirmar && sel_ok) ? col_sel : auto_col;
        end
        ESCRIBE: begin
          for (int unsigned i = 0; i < COLS; i++) begin
            if ((col_q == 3'(i)) && (altura[i] < ROWS_L)) altura[i] <= altura[i] + 3'd1;
          end
          movs <= movs + 6'd1;
        end
        VERIFICA: begin
          if (chequeo_listo && hay_ganador) ganador <= is_red;
          if (next == CAMBIO) segundos <= SEC_INIT;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_partida.sv
// Self-checking bench for control_partida. A behavioural model (column
// heights, move count, ESPERA cycle count) predicts every observable output.
module tb_control_partida;

  localparam int COLS     = 7;
  localparam int ROWS     = 6;
  localparam int CLK_HZ   = 4;
  localparam int TURN_SEC = 2;
  localparam int LIMIT    = TURN_SEC * CLK_HZ;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic [2:0] col_sel = '0;
  logic       confirmar = 1'b0;
  logic       is_red = 1'b0;
  logic       chequeo_listo = 1'b0;
  logic       hay_ganador = 1'b0;
  logic       listo, wr_en, wr_color, chequeo_req, ficha_colocada, jugada_invalida, ganador;
  logic [2:0] wr_fila, wr_col;
  logic [3:0] segundos;
  logic [1:0] estado_juego;

  control_partida #(
    .COLS(COLS), .ROWS(ROWS), .CLK_HZ(CLK_HZ), .TURN_SEC(TURN_SEC)
  ) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .col_sel(col_sel),
    .confirmar(confirmar), .is_red(is_red), .chequeo_listo(chequeo_listo),
    .hay_ganador(hay_ganador), .listo(listo), .wr_en(wr_en), .wr_fila(wr_fila),
    .wr_col(wr_col), .wr_color(wr_color), .chequeo_req(chequeo_req),
    .ficha_colocada(ficha_colocada), .jugada_invalida(jugada_invalida),
    .segundos(segundos), .estado_juego(estado_juego), .ganador(ganador)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int m_alt[8];
  int m_moves;
  int esp_edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int first_free();
    for (int c = 0; c < COLS; c++) if (m_alt[c] < ROWS) return c;
    return 0;
  endfunction

  function automatic int m_secs();
    return TURN_SEC - esp_edges / CLK_HZ;
  endfunction

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_listo"}, listo, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_fila"}, wr_fila, 0);
    chk({tag, "_wr_col"}, wr_col, 0);
    chk({tag, "_wr_color"}, wr_color, 0);
    chk({tag, "_chequeo_req"}, chequeo_req, 0);
    chk({tag, "_ficha"}, ficha_colocada, 0);
    chk({tag, "_invalida"}, jugada_invalida, 0);
    chk({tag, "_segundos"}, segundos, TURN_SEC);
    chk({tag, "_estado"}, estado_juego, 0);
    chk({tag, "_ganador"}, ganador, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0; inicio = 1'b0; confirmar = 1'b0;
    chequeo_listo = 1'b0; hay_ganador = 1'b0; col_sel = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_estado", estado_juego, 0);
    chk("idle_listo", listo, 0);
  endtask

  task automatic start_game();
    for (int c = 0; c < 8; c++) m_alt[c] = 0;
    m_moves = 0;
    inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    chk("start_listo", listo, 1);
    chk("start_estado", estado_juego, 1);
    chk("start_segundos", segundos, TURN_SEC);
    esp_edges = 0;
  endtask

  // One clock edge spent in ESPERA. Reports whether a move was started and
  // which column the model expects to be written.
  task automatic esp_step(input bit conf, input int col, output bit moved, output int mcol);
    bit valid;
    col_sel = 3'(col);
    confirmar = conf;
    chequeo_listo = 1'($urandom_range(0, 1));
    hay_ganador = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    confirmar = 1'b0; chequeo_listo = 1'b0; hay_ganador = 1'b0;
    esp_edges++;
    valid = conf && (col < COLS) && (m_alt[col] < ROWS);
    chk("invalida", jugada_invalida, (conf && !valid) ? 1 : 0);
    chk("listo_low", listo, 0);
    moved = 1'b0;
    mcol = 0;
    if (valid) begin
      moved = 1'b1; mcol = col;
    end else if (esp_edges == LIMIT) begin
      moved = 1'b1; mcol = first_free();
    end else begin
      chk("espera_wr_en", wr_en, 0);
      chk("espera_segundos", segundos, m_secs());
      chk("espera_estado", estado_juego, 1);
    end
  endtask

  // Called in the ESCRIBE cycle; runs through VERIFICA and, if the game
  // continues, CAMBIO, ending in the first cycle of the next ESPERA.
  task automatic finish_move(input int col, input bit win, input int dly, output bit over);
    chk("wr_en", wr_en, 1);
    chk("wr_col", wr_col, col);
    chk("wr_fila", wr_fila, m_alt[col]);
    chk("wr_color", wr_color, is_red);
    chk("escribe_segundos", segundos, m_secs());
    chk("escribe_req", chequeo_req, 0);
    m_alt[col]++;
    m_moves++;
    @(posedge clk); #1;
    chk("verifica_wr_en", wr_en, 0);
    chk("verifica_req", chequeo_req, 1);
    repeat (dly) begin
      @(posedge clk); #1;
      chk("verifica_hold", chequeo_req, 1);
      chk("verifica_ficha", ficha_colocada, 0);
    end
    chequeo_listo = 1'b1;
    hay_ganador = win;
    @(posedge clk); #1;
    chequeo_listo = 1'b0; hay_ganador = 1'b0;
    chk("post_req", chequeo_req, 0);
    over = 1'b1;
    if (win) begin
      chk("win_estado", estado_juego, 2);
      chk("win_ganador", ganador, is_red);
      chk("win_ficha", ficha_colocada, 0);
    end else if (m_moves == ROWS * COLS) begin
      chk("draw_estado", estado_juego, 3);
      chk("draw_ficha", ficha_colocada, 0);
    end else begin
      over = 1'b0;
      chk("cambio_ficha", ficha_colocada, 1);
      chk("cambio_segundos", segundos, TURN_SEC);
      chk("cambio_estado", estado_juego, 1);
      @(posedge clk); #1;
      esp_edges = 0;
      chk("ficha_pulse_end", ficha_colocada, 0);
      chk("espera_reload", segundos, TURN_SEC);
    end
  endtask

  task automatic fin_checks(input int est);
    for (int k = 0; k < 4; k++) begin
      inicio = 1'b1;
      confirmar = 1'b1;
      col_sel = 3'($urandom_range(0, 7));
      chequeo_listo = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("fin_wr_en", wr_en, 0);
      chk("fin_estado", estado_juego, est);
      chk("fin_listo", listo, 0);
      chk("fin_invalida", jugada_invalida, 0);
      chk("fin_ficha", ficha_colocada, 0);
    end
    inicio = 1'b0; confirmar = 1'b0; chequeo_listo = 1'b0;
  endtask

  task automatic play_random(input int win_pct);
    bit over, moved, conf;
    int mcol, col;
    over = 1'b0;
    while (!over) begin
      is_red = 1'($urandom_range(0, 1));
      moved = 1'b0;
      while (!moved) begin
        conf = ($urandom_range(0, 3) != 0);
        col = $urandom_range(0, 7);
        esp_step(conf, col, moved, mcol);
      end
      finish_move(mcol, ($urandom_range(0, 99) < win_pct), $urandom_range(0, 3), over);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit over, moved;
    int mcol, steps;

    apply_reset();
    start_game();

    // Three stacked red moves in column 3.
    is_red = 1'b1;
    for (int k = 0; k < 3; k++) begin
      esp_step(1'b1, 3, moved, mcol);
      chk("stack_row", wr_fila, k);
      finish_move(mcol, 1'b0, k, over);
    end

    // Fill column 0, then reject a full column and an out-of-range column.
    for (int k = 0; k < ROWS; k++) begin
      is_red = 1'(k % 2);
      esp_step(1'b1, 0, moved, mcol);
      finish_move(mcol, 1'b0, 0, over);
    end
    esp_step(1'b1, 0, moved, mcol);
    chk("full_col_rejected", jugada_invalida, 1);
    esp_step(1'b1, 7, moved, mcol);
    chk("col7_rejected", jugada_invalida, 1);
    esp_step(1'b1, 2, moved, mcol);
    finish_move(mcol, 1'b0, 1, over);

    // Timeout with no input: auto move into the first non-full column.
    steps = 0;
    moved = 1'b0;
    while (!moved && steps < 4 * LIMIT) begin
      esp_step(1'b0, 0, moved, mcol);
      steps++;
    end
    chk("auto_wr_en", wr_en, 1);
    chk("auto_col", wr_col, 1);
    chk("auto_segundos", segundos, 0);
    finish_move(mcol, 1'b0, 2, over);

    // Red wins; terminal state ignores further input.
    is_red = 1'b1;
    esp_step(1'b1, 4, moved, mcol);
    finish_move(mcol, 1'b1, 1, over);
    chk("win_red", ganador, 1);
    fin_checks(2);

    // Full board without a winner.
    apply_reset();
    start_game();
    play_random(0);
    chk("draw_moves_estado", estado_juego, 3);
    fin_checks(3);

    // Random game with occasional wins.
    apply_reset();
    start_game();
    play_random(4);

    // Reset asserted in the middle of VERIFICA.
    apply_reset();
    start_game();
    is_red = 1'b1;
    esp_step(1'b1, 5, moved, mcol);
    chk("mid_wr_en", wr_en, 1);
    @(posedge clk); #1;
    chk("mid_req_before", chequeo_req, 1);
    reset = 1'b0;
    #1;
    chk("mid_req_cleared", chequeo_req, 0);
    chk("mid_estado", estado_juego, 0);
    chk("mid_segundos", segundos, TURN_SEC);
    chk("mid_wr_en_cleared", wr_en, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_idle_estado", estado_juego, 0);
    chk("mid_idle_wr_en", wr_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
